// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit.
//   cond_t  : ARM condition field encodings (Instr[31:28])
//   flags_t : packed NZCV flag vector, indexed by the FLAG_* constants
package cond_pkg;

    typedef enum logic [3:0] {
        CondEq = 4'b0000,
        CondNe = 4'b0001,
        CondCs = 4'b0010,
        CondCc = 4'b0011,
        CondMi = 4'b0100,
        CondPl = 4'b0101,
        CondVs = 4'b0110,
        CondVc = 4'b0111,
        CondHi = 4'b1000,
        CondLs = 4'b1001,
        CondGe = 4'b1010,
        CondLt = 4'b1011,
        CondGt = 4'b1100,
        CondLe = 4'b1101,
        CondAl = 4'b1110,
        CondNv = 4'b1111
    } cond_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator.
//   cond_i     : 4-bit condition field
//   flags_i    : NZCV flags to test against
//   condpass_o : 1 when the condition holds
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       condpass_o
);

    logic n, z, c, v;

    always_comb begin
        n = flags_i[FLAG_N];
        z = flags_i[FLAG_Z];
        c = flags_i[FLAG_C];
        v = flags_i[FLAG_V];
        condpass_o = 1'b0;
        case (cond_t'(cond_i))
            CondEq:  condpass_o = z;
            CondNe:  condpass_o = ~z;
            CondCs:  condpass_o = c;
            CondCc:  condpass_o = ~c;
            CondMi:  condpass_o = n;
            CondPl:  condpass_o = ~n;
            CondVs:  condpass_o = v;
            CondVc:  condpass_o = ~v;
            CondHi:  condpass_o = c & ~z;
            CondLs:  condpass_o = ~c | z;
            CondGe:  condpass_o = (n == v);
            CondLt:  condpass_o = (n != v);
            CondGt:  condpass_o = ~z & (n == v);
            CondLe:  condpass_o = z | (n != v);
            CondAl:  condpass_o = 1'b1;
            default: condpass_o = 1'b0;  // 1111: never
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural NZCV register, a
// single-entry saved-flags register and a saturating skipped-instruction
// counter; evaluates the instruction condition and gates decoder strobes.
//   Inputs : clk, reset (async, active-high), Cond, ALUFlags, FlagW, PCS,
//            RegW, MemW, NoWrite, Stall, Flush, SaveFlags, RestoreFlags
//   Outputs: PCSrc, RegWrite, MemWrite, CondEx (combinational),
//            Flags, Carry, SkipCount (registered state)
module cond_unit
    import cond_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      Cond,
    input  logic [3:0]      ALUFlags,
    input  logic [1:0]      FlagW,
    input  logic            PCS,
    input  logic            RegW,
    input  logic            MemW,
    input  logic            NoWrite,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            SaveFlags,
    input  logic            RestoreFlags,
    output logic            PCSrc,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            CondEx,
    output logic [3:0]      Flags,
    output logic            Carry,
    output logic [CNTW-1:0] SkipCount
);

    flags_t            flags_q, flags_d;
    flags_t            saved_flags_q, saved_flags_d;
    logic [CNTW-1:0]   skip_cnt_q, skip_cnt_d;
    logic              condpass;
    logic              upd;

    // Condition is always tested against the registered flags so a
    // flag-setting op in cycle n steers the instruction in cycle n+1.
    cond_check u_cond_check (
        .cond_i     (Cond),
        .flags_i    (flags_q),
        .condpass_o (condpass)
    );

    always_comb begin
        CondEx   = condpass & ~Flush;
        PCSrc    = PCS & CondEx;
        MemWrite = MemW & CondEx;
        RegWrite = RegW & CondEx & ~NoWrite;
        upd      = ~Stall & ~Flush & CondEx;
    end

    always_comb begin
        flags_d = flags_q;
        if (upd && FlagW[1]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (upd && FlagW[0]) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
        // Restore wins over any ALU write and ignores Flush/CondEx.
        if (!Stall && RestoreFlags) begin
            flags_d = saved_flags_q;
        end

        // Save takes the pre-edge value; with Restore this forms a swap.
        saved_flags_d = saved_flags_q;
        if (!Stall && SaveFlags) begin
            saved_flags_d = flags_q;
        end

        skip_cnt_d = skip_cnt_q;
        if (!Stall && !Flush && !condpass && (skip_cnt_q != {CNTW{1'b1}})) begin
            skip_cnt_d = skip_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q       <= '0;
            saved_flags_q <= '0;
            skip_cnt_q    <= '0;
        end else begin
            flags_q       <= flags_d;
            saved_flags_q <= saved_flags_d;
            skip_cnt_q    <= skip_cnt_d;
        end
    end

    assign Flags     = flags_q;
    assign Carry     = flags_q[FLAG_C];
    assign SkipCount = skip_cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: the driver applies one instruction per
// cycle and queues the hand-computed outputs expected for that cycle; the
// monitor pops and compares on the falling edge.
module tb_cond_unit;

    localparam int unsigned CNTW = 4;

    // Control-bit masks for the compact stimulus encoding.
    localparam logic [8:0] C_PCS  = 9'h001;
    localparam logic [8:0] C_REGW = 9'h002;
    localparam logic [8:0] C_MEMW = 9'h004;
    localparam logic [8:0] C_NW   = 9'h008;
    localparam logic [8:0] C_ST   = 9'h010;
    localparam logic [8:0] C_FL   = 9'h020;
    localparam logic [8:0] C_SV   = 9'h040;
    localparam logic [8:0] C_RS   = 9'h080;
    localparam logic [8:0] C_RST  = 9'h100;

    logic            clk, reset;
    logic [3:0]      Cond, ALUFlags;
    logic [1:0]      FlagW;
    logic            PCS, RegW, MemW, NoWrite, Stall, Flush, SaveFlags, RestoreFlags;
    logic            PCSrc, RegWrite, MemWrite, CondEx, Carry;
    logic [3:0]      Flags;
    logic [CNTW-1:0] SkipCount;

    cond_unit #(.CNTW(CNTW)) dut (
        .clk          (clk),
        .reset        (reset),
        .Cond         (Cond),
        .ALUFlags     (ALUFlags),
        .FlagW        (FlagW),
        .PCS          (PCS),
        .RegW         (RegW),
        .MemW         (MemW),
        .NoWrite      (NoWrite),
        .Stall        (Stall),
        .Flush        (Flush),
        .SaveFlags    (SaveFlags),
        .RestoreFlags (RestoreFlags),
        .PCSrc        (PCSrc),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .CondEx       (CondEx),
        .Flags        (Flags),
        .Carry        (Carry),
        .SkipCount    (SkipCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // outs = {PCSrc, RegWrite, MemWrite, CondEx}
    typedef struct {
        string           name;
        logic [3:0]      outs;
        logic [3:0]      flags;
        logic [CNTW-1:0] skip;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input string field,
                         input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "outs",  {4'b0, PCSrc, RegWrite, MemWrite, CondEx}, {4'b0, e.outs});
            check(e.name, "flags", {4'b0, Flags}, {4'b0, e.flags});
            check(e.name, "carry", {7'b0, Carry}, {7'b0, e.flags[1]});
            check(e.name, "skip",  {{(8-CNTW){1'b0}}, SkipCount}, {{(8-CNTW){1'b0}}, e.skip});
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue the
    // outputs expected before the next edge.
    task automatic step(input string name, input logic [3:0] cond, input logic [3:0] alu,
                        input logic [1:0] fw, input logic [8:0] ctl,
                        input logic [3:0] eo, input logic [3:0] ef,
                        input logic [CNTW-1:0] es);
        exp_t e;
        @(posedge clk);
        #1;
        Cond         = cond;
        ALUFlags     = alu;
        FlagW        = fw;
        PCS          = |(ctl & C_PCS);
        RegW         = |(ctl & C_REGW);
        MemW         = |(ctl & C_MEMW);
        NoWrite      = |(ctl & C_NW);
        Stall        = |(ctl & C_ST);
        Flush        = |(ctl & C_FL);
        SaveFlags    = |(ctl & C_SV);
        RestoreFlags = |(ctl & C_RS);
        reset        = |(ctl & C_RST);
        e.name  = name;
        e.outs  = eo;
        e.flags = ef;
        e.skip  = es;
        exp_q.push_back(e);
    endtask

    initial begin
        int wait_cycles;
        reset = 1'b1;
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; Stall = 0; Flush = 0;
        SaveFlags = 0; RestoreFlags = 0;
        repeat (2) @(posedge clk);

        //    name            cond   alu    fw     ctl                    outs     flags  skip
        step("rst_eq",        4'h0, 4'h0, 2'b00, C_PCS,                 4'b0000, 4'h0, 4'd0);
        step("rst_al",        4'he, 4'h0, 2'b00, C_REGW,                4'b0101, 4'h0, 4'd1);
        step("cmp_eq",        4'he, 4'h6, 2'b11, 9'h000,                4'b0001, 4'h0, 4'd1);
        step("beq",           4'h0, 4'h0, 2'b00, C_PCS,                 4'b1001, 4'h6, 4'd1);
        step("bne",           4'h1, 4'h0, 2'b00, C_PCS,                 4'b0000, 4'h6, 4'd1);
        step("adc_cs",        4'h2, 4'h0, 2'b00, C_REGW,                4'b0101, 4'h6, 4'd2);
        step("cmp_nowrite",   4'he, 4'h0, 2'b00, C_REGW | C_NW | C_MEMW, 4'b0011, 4'h6, 4'd2);
        step("clr",           4'he, 4'h0, 2'b11, 9'h000,                4'b0001, 4'h6, 4'd2);
        step("gated_fail",    4'h0, 4'hf, 2'b11, 9'h000,                4'b0000, 4'h0, 4'd2);
        step("nz_only",       4'he, 4'hf, 2'b10, 9'h000,                4'b0001, 4'h0, 4'd3);
        step("mi",            4'h4, 4'h0, 2'b00, C_PCS,                 4'b1001, 4'hc, 4'd3);
        step("le",            4'hd, 4'h0, 2'b00, 9'h000,                4'b0001, 4'hc, 4'd3);
        step("ge",            4'ha, 4'h0, 2'b00, 9'h000,                4'b0000, 4'hc, 4'd3);
        step("hi",            4'h8, 4'h0, 2'b00, 9'h000,                4'b0000, 4'hc, 4'd4);
        for (int i = 0; i < 3; i++)
            step("stall",     4'he, 4'ha, 2'b11, C_ST | C_MEMW,         4'b0011, 4'hc, 4'd5);
        step("stall_fail",    4'hf, 4'h0, 2'b00, C_ST,                  4'b0000, 4'hc, 4'd5);
        step("flush",         4'he, 4'ha, 2'b11, C_FL | C_MEMW,         4'b0000, 4'hc, 4'd5);
        step("flush_fail",    4'hf, 4'h0, 2'b00, C_FL,                  4'b0000, 4'hc, 4'd5);
        step("set1001",       4'he, 4'h9, 2'b11, 9'h000,                4'b0001, 4'hc, 4'd5);
        step("save",          4'he, 4'h6, 2'b11, C_SV,                  4'b0001, 4'h9, 4'd5);
        step("restore",       4'he, 4'h0, 2'b11, C_RS,                  4'b0001, 4'h6, 4'd5);
        step("set0011",       4'he, 4'h3, 2'b11, 9'h000,                4'b0001, 4'h9, 4'd5);
        step("swap",          4'he, 4'h0, 2'b00, C_SV | C_RS,           4'b0001, 4'h3, 4'd5);
        step("post_swap",     4'he, 4'h0, 2'b00, C_RS,                  4'b0001, 4'h9, 4'd5);
        step("post_swap2",    4'he, 4'h0, 2'b00, 9'h000,                4'b0001, 4'h3, 4'd5);
        step("stall_swap",    4'he, 4'h0, 2'b00, C_ST | C_SV | C_RS,    4'b0001, 4'h3, 4'd5);
        step("after_stall",   4'he, 4'h0, 2'b00, 9'h000,                4'b0001, 4'h3, 4'd5);
        // 20 never-executed instructions: 5 counts to 15, then holds.
        for (int k = 0; k < 20; k++)
            step("sat", 4'hf, 4'h0, 2'b00, 9'h000, 4'b0000, 4'h3,
                 (5 + k > 15) ? 4'd15 : 4'(5 + k));
        step("sat_hold",      4'hf, 4'h0, 2'b00, 9'h000,                4'b0000, 4'h3, 4'd15);
        // Reset asserted mid-cycle: state must clear before any edge.
        step("mid_reset",     4'h1, 4'h0, 2'b00, C_RST | C_PCS,         4'b1001, 4'h0, 4'd0);
        step("rst_restore",   4'he, 4'h0, 2'b00, C_RS,                  4'b0001, 4'h0, 4'd0);
        step("rst_saved",     4'he, 4'h0, 2'b00, 9'h000,                4'b0001, 4'h0, 4'd0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
